pueo_trig_capture: RTL and testbench

- Sits directly downstream of the level-two trigger stage.
- Consumes its single-cycle master trigger pulse and its four delay-aligned 64-bit TIO metadata words.
- Stamps each accepted trigger with an event number and a ce-tick timestamp, then buffers the record in a small first-word-fall-through (FWFT) FIFO for the event builder.
- Generates the holdoff and dead signals that feed back into the level-two stage.

---
 rtl/pueo_trig_pkg.sv | 15 +
 rtl/pueo_trig_record_fifo.sv | 63 ++++++
 rtl/pueo_trig_capture.sv | 119 +++++++++++
 tb/tb_pueo_trig_capture.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_trig_pkg.sv
// Shared types for the PUEO trigger capture block.
// Record layout: event number, ce-tick timestamp, four TIO metadata words.
package pueo_trig_pkg;

    localparam int TRIG_TIME_BITS  = 48;
    localparam int TRIG_EVNUM_BITS = 32;
    localparam int TRIG_DROP_BITS  = 16;

    typedef struct packed {
        logic [TRIG_EVNUM_BITS-1:0] evt_num;
        logic [TRIG_TIME_BITS-1:0]  evt_time;
        logic [3:0][63:0]           meta;
    } trig_record_t;

endpackage

// File: rtl/pueo_trig_record_fifo.sv
// Synchronous first-word-fall-through FIFO of trigger records.
// Head data reads as zero while the FIFO is empty.
module pueo_trig_record_fifo
    import pueo_trig_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  trig_record_t        wr_data_i,
    input  logic                pop_i,
    output trig_record_t        rd_data_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                full_o,
    output logic                empty_o
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    trig_record_t          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count == FULL_CNT);
    assign empty_o = (count == '0);
    assign count_o = count;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign rd_data_o = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                do_push && !do_pop: count <= count + 1'b1;
                do_pop && !do_push: count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pueo_trig_capture.sv
// Trigger capture: stamps L2 triggers, buffers records, drives holdoff/dead.
// Define PUEO_TRIG_DROP_COUNT_EN to build the saturating drop counter.
module pueo_trig_capture
    import pueo_trig_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int HOLDOFF_BITS    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ce_i,
    input  logic                        en_i,
    input  logic                        trig_i,
    input  logic [63:0]                 tio0_meta_i,
    input  logic [63:0]                 tio1_meta_i,
    input  logic [63:0]                 tio2_meta_i,
    input  logic [63:0]                 tio3_meta_i,
    input  logic [HOLDOFF_BITS-1:0]     holdoff_len_i,
    output logic                        holdoff_o,
    output logic                        dead_o,
    output logic                        evt_valid_o,
    input  logic                        evt_ready_i,
    output logic [TRIG_EVNUM_BITS-1:0]  evt_num_o,
    output logic [TRIG_TIME_BITS-1:0]   evt_time_o,
    output logic [255:0]                evt_meta_o,
    output logic [FIFO_DEPTH_LOG2:0]    fifo_count_o,
    output logic [TRIG_DROP_BITS-1:0]   drop_count_o
);

    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEAD_LVL = CW'(2 ** FIFO_DEPTH_LOG2 - 1);

    logic [TRIG_TIME_BITS-1:0]  ts_q;
    logic [TRIG_EVNUM_BITS-1:0] evnum_q;
    logic [HOLDOFF_BITS-1:0]    hold_q;
    logic                       dead_q;
    logic                       full;
    logic                       empty;
    logic [CW-1:0]              count;
    logic [CW-1:0]              occ_next;
    logic                       accept;
    logic                       pop;
    trig_record_t               wr_rec;
    trig_record_t               rd_rec;

    assign accept   = trig_i && en_i && !full;
    assign pop      = !empty && evt_ready_i;
    assign occ_next = count + CW'(accept) - CW'(pop);

    assign wr_rec.evt_num  = evnum_q;
    assign wr_rec.evt_time = ts_q;
    assign wr_rec.meta     = {tio3_meta_i, tio2_meta_i,
                              tio1_meta_i, tio0_meta_i};

    pueo_trig_record_fifo #(
        .DEPTH_LOG2(FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (accept),
        .wr_data_i(wr_rec),
        .pop_i    (pop),
        .rd_data_o(rd_rec),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    assign evt_valid_o  = !empty;
    assign evt_num_o    = rd_rec.evt_num;
    assign evt_time_o   = rd_rec.evt_time;
    assign evt_meta_o   = rd_rec.meta;
    assign fifo_count_o = count;
    assign holdoff_o    = (hold_q != '0);
    assign dead_o       = dead_q;

    // Dropped triggers still consume an event number so gaps show downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q    <= '0;
            evnum_q <= '0;
            hold_q  <= '0;
            dead_q  <= 1'b1;
        end else begin
            if (ce_i) begin
                ts_q <= ts_q + 1'b1;
            end
            if (trig_i && en_i) begin
                evnum_q <= evnum_q + 1'b1;
            end
            if (accept) begin
                hold_q <= holdoff_len_i;
            end else if (ce_i && hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
            dead_q <= !en_i || (occ_next >= DEAD_LVL);
        end
    end

`ifdef PUEO_TRIG_DROP_COUNT_EN
    logic [TRIG_DROP_BITS-1:0] drop_q;
    logic                      drop;

    assign drop = trig_i && en_i && full;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q <= '0;
        end else if (drop && drop_q != '1) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign drop_count_o = drop_q;
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_pueo_trig_capture.sv
// Directed self-checking bench for pueo_trig_capture.
module tb_pueo_trig_capture;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ce_i;
    logic         en_i;
    logic         trig_i;
    logic [63:0]  tio0_meta_i;
    logic [63:0]  tio1_meta_i;
    logic [63:0]  tio2_meta_i;
    logic [63:0]  tio3_meta_i;
    logic [15:0]  holdoff_len_i;
    logic         holdoff_o;
    logic         dead_o;
    logic         evt_valid_o;
    logic         evt_ready_i;
    logic [31:0]  evt_num_o;
    logic [47:0]  evt_time_o;
    logic [255:0] evt_meta_o;
    logic [4:0]   fifo_count_o;
    logic [15:0]  drop_count_o;

    int passed = 0;
    int total  = 0;
    bit alt    = 1'b0;
    int n;

`ifdef PUEO_TRIG_DROP_COUNT_EN
    localparam logic [15:0] DROP1 = 16'd1;
`else
    localparam logic [15:0] DROP1 = 16'd0;
`endif

    always #5 clk_i = ~clk_i;

    pueo_trig_capture dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ce_i         (ce_i),
        .en_i         (en_i),
        .trig_i       (trig_i),
        .tio0_meta_i  (tio0_meta_i),
        .tio1_meta_i  (tio1_meta_i),
        .tio2_meta_i  (tio2_meta_i),
        .tio3_meta_i  (tio3_meta_i),
        .holdoff_len_i(holdoff_len_i),
        .holdoff_o    (holdoff_o),
        .dead_o       (dead_o),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_num_o    (evt_num_o),
        .evt_time_o   (evt_time_o),
        .evt_meta_o   (evt_meta_o),
        .fifo_count_o (fifo_count_o),
        .drop_count_o (drop_count_o)
    );

    task automatic chk(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (alt) ce_i = ~ce_i;
    endtask

    task automatic pulse(input logic [63:0] m);
        trig_i      = 1'b1;
        tio0_meta_i = m;
        step();
        trig_i = 1'b0;
    endtask

    task automatic count_hold(output int cnt);
        cnt = holdoff_o ? 1 : 0;
        for (int i = 0; i < 64 && holdoff_o; i++) begin
            step();
            if (holdoff_o) cnt = cnt + 1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; ce_i = 1'b1; en_i = 1'b1; trig_i = 1'b0;
        tio0_meta_i = '0;
        tio1_meta_i = 64'hA1A1_A1A1_A1A1_A1A1;
        tio2_meta_i = 64'hB2B2_B2B2_B2B2_B2B2;
        tio3_meta_i = 64'hC3C3_C3C3_C3C3_C3C3;
        holdoff_len_i = '0; evt_ready_i = 1'b0;
        step(); step();

        chk("rst_valid", evt_valid_o, 0);
        chk("rst_dead", dead_o, 1);
        chk("rst_holdoff", holdoff_o, 0);
        chk("rst_count", fifo_count_o, 0);
        chk("rst_num", evt_num_o, 0);
        chk("rst_time", evt_time_o, 0);
        chk("rst_meta", evt_meta_o, 0);
        chk("rst_drop", drop_count_o, 0);

        rst_i = 1'b0;
        step();
        chk("dead_after_rst", dead_o, 0);
        repeat (99) step();
        pulse(64'h1122_3344_5566_7788);
        chk("t1_valid", evt_valid_o, 1);
        chk("t1_num", evt_num_o, 0);
        chk("t1_time", evt_time_o, 100);
        chk("t1_meta0", evt_meta_o[63:0], 64'h1122_3344_5566_7788);
        chk("t1_meta", evt_meta_o,
            {64'hC3C3_C3C3_C3C3_C3C3, 64'hB2B2_B2B2_B2B2_B2B2,
             64'hA1A1_A1A1_A1A1_A1A1, 64'h1122_3344_5566_7788});
        evt_ready_i = 1'b1;
        step();
        chk("t1_popped", evt_valid_o, 0);

        holdoff_len_i = 16'd5; ce_i = 1'b1; alt = 1'b1;
        pulse(64'h0);
        chk("ho_start", holdoff_o, 1);
        count_hold(n);
        chk("ho_clocks", n, 10);
        ce_i = 1'b1;
        pulse(64'h0);
        repeat (7) step();
        chk("ho_mid", holdoff_o, 1);
        pulse(64'h0);
        count_hold(n);
        chk("ho_reload", n, 10);
        holdoff_len_i = 16'd0;
        pulse(64'h0);
        chk("ho_zero", holdoff_o, 0);
        alt = 1'b0; ce_i = 1'b1;

        rst_i = 1'b1; evt_ready_i = 1'b0;
        step();
        rst_i = 1'b0;
        step();
        for (int i = 1; i <= 16; i++) begin
            pulse(64'(i));
            step(); step();
            chk("fill_count", fifo_count_o, i);
            chk("fill_dead", dead_o, (i >= 15) ? 1 : 0);
        end
        pulse(64'hDEAD);
        chk("full_count", fifo_count_o, 16);
        chk("full_drop", drop_count_o, DROP1);
        evt_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_num", evt_num_o, i);
            step();
        end
        chk("drain_empty", evt_valid_o, 0);
        chk("drain_dead", dead_o, 0);
        evt_ready_i = 1'b0;
        pulse(64'h0);
        chk("gap_num", evt_num_o, 17);

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        for (int i = 0; i < 8; i++) pulse(64'(i));
        chk("pp_count8", fifo_count_o, 8);
        for (int i = 0; i < 4; i++) begin
            chk("pp_head", evt_num_o, i);
            evt_ready_i = 1'b1; trig_i = 1'b1;
            tio0_meta_i = 64'(8 + i);
            step();
            trig_i = 1'b0; evt_ready_i = 1'b0;
            chk("pp_count", fifo_count_o, 8);
        end
        evt_ready_i = 1'b1;
        for (int i = 4; i < 12; i++) begin
            chk("pp_num", evt_num_o, i);
            chk("pp_meta", evt_meta_o[63:0], i);
            step();
        end
        evt_ready_i = 1'b0;
        chk("pp_done", fifo_count_o, 0);

        en_i = 1'b0;
        step();
        chk("dis_dead", dead_o, 1);
        for (int i = 0; i < 3; i++) begin
            pulse(64'hF00D);
            chk("dis_count", fifo_count_o, 0);
        end
        en_i = 1'b1;
        step();
        chk("en_dead", dead_o, 0);
        pulse(64'h0);
        chk("en_num", evt_num_o, 12);
        evt_ready_i = 1'b1;
        step();
        evt_ready_i = 1'b0;

        holdoff_len_i = 16'd20;
        for (int i = 0; i < 4; i++) pulse(64'(i));
        chk("pre_rst_count", fifo_count_o, 4);
        chk("pre_rst_hold", holdoff_o, 1);
        rst_i = 1'b1;
        step();
        chk("mid_rst_valid", evt_valid_o, 0);
        chk("mid_rst_hold", holdoff_o, 0);
        chk("mid_rst_count", fifo_count_o, 0);
        chk("mid_rst_dead", dead_o, 1);
        rst_i = 1'b0;
        step();
        pulse(64'h0);
        chk("post_rst_num", evt_num_o, 0);
        chk("post_rst_time", evt_time_o, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
